div_result_display: RTL and testbench
=====================================

// Module: div_result_display
// PURPOSE
// - Downstream stage of the 8-bit/4-bit divider: captures quotient[7:0] and remainder[3:0] on a load pulse.
// - Converts the quotient to 3 BCD digits with a sequential double-dabble, 1 bit per clock.
// - Drives a 4-digit time-multiplexed 7-segment display: hundreds, tens, ones of the quotient, then the remainder as hex.
// PARAMETERS
// - SCAN_DIV  100000  clk cycles per digit dwell; legal range >= 2
// PORTS
// - clk        in   1  system clock; all state updates on the rising edge
// - rst        in   1  asynchronous, active-high reset
// - quotient   in   8  divider quotient, sampled only when load is accepted
// - remainder  in   4  divider remainder, sampled with quotient
// - load       in   1  single-cycle capture request
// - busy       out  1  high while a conversion is in progress
// - an         out  4  digit enables, active low; an[3]=hundreds ... an[0]=remainder
// - seg        out  7  segments {g,f,e,d,c,b,a}, active low
// BEHAVIOUR
// - Reset (async): state=S_IDLE, busy=0, an=4'b1111, seg=7'h7F, digit registers cleared, scan counter=0, digit index=0.
// - FSM states:
//   - S_IDLE: display blank (an=4'b1111). load=1 -> S_CONV.
//   - S_CONV: fixed 8 cycles. load is ignored.
//   - S_SHOW: scanning. load=1 -> S_CONV.
// - Load acceptance edge: latch quotient and remainder; shift reg sr[19:0] = {12'h000, quotient}; bit counter = 0.
// - Each S_CONV cycle:
//   - Add 3 to every BCD nibble of sr[19:8] that is >= 5.
//   - Then shift sr left by 1 and increment the bit counter.
// - On the 8th S_CONV cycle (counter==7):
//   - Commit hundreds/tens/ones from the post-shift value, together with the latched remainder, to the display registers.
//   - Go to S_SHOW.
// - busy = (state==S_CONV), registered; it is high during exactly 8 cycles starting the cycle after load is sampled.
// - First valid display data: 9 clocks after the load edge. Display registers hold their old value until that commit.
// - Scan counter runs in all states:
//   - It counts 0..SCAN_DIV-1, then wraps to 0.
//   - On each wrap, digit index advances 0->1->2->3->0.
//   - Index 0 selects hundreds (an=4'b0111); index 3 selects remainder (an=4'b1110).
// - an and seg are registered. They update one cycle after an index change, so no glitch between digits.
// - In S_CONV the display keeps showing the previous committed digits, or blank if coming from S_IDLE.
// - load and S_CONV completion never collide, because load is ignored in S_CONV.
// - Reset asserted mid-conversion: everything aborts to reset values immediately; partial results are discarded.
// - Quotient 0xFF (divide-by-zero pattern from the divider) displays as 2,5,5; no special handling.
// CONFIGURATION
// - Macro LEADING_ZERO_BLANK_EN.
// - Defined: in S_SHOW, the hundreds digit is blanked when it is 0 (seg=7'h7F, anode still driven). Tens is blanked when hundreds and tens are both 0.
// - The ones and remainder digits are never blanked.
// - Undefined: all four digits are always shown, e.g. "007".
// STRUCTURE
// - Shared package/include div_disp_pkg:
//   - state encodings S_IDLE=2'd0, S_CONV=2'd1, S_SHOW=2'd2
//   - SEG_BLANK=7'h7F
//   - BCD_WIDTH=12
// - Sub-module seg7_decode: combinational 4-bit hex -> active-low 7-seg.
//   - It covers 0-F, since the remainder digit uses hex.
//   - One instance is shared across the muxed digit.
// TESTING (bench uses SCAN_DIV=4)
// - Reset: assert rst async mid-cycle -> an=4'hF, seg=7'h7F, busy=0 immediately, without waiting for a clk edge.
// - Load q=8'hFF, r=4'h3 -> busy high for 8 cycles; after the commit the scan shows 2,5,5,3 on an=0111,1011,1101,1110.
// - Load q=8'd100, r=4'hA during S_SHOW; then pulse load=1 with q=8'd9 at conversion cycle 4 -> second load ignored; display 1,0,0,A.
// - Scan wrap: observe 16 cycles in S_SHOW -> each digit is held for exactly 4 cycles, and index 3 wraps to 0.
// - Assert rst at conversion cycle 5 -> display blank; busy=0; after release, state is S_IDLE and there is no commit.
// - Load q=8'd7, r=4'h0:
//   - with LEADING_ZERO_BLANK_EN -> blank, blank, 7, 0
//   - without it -> 0, 0, 7, 0

Source files
------------

// File: rtl/div_disp_pkg.sv
// Shared definitions for the divider result display: FSM encoding, blank pattern, BCD width.
package div_disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_SHOW = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int         BCD_WIDTH = 12;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low 7-segment pattern, segment order {g,f,e,d,c,b,a}.
module seg7_decode
    import div_disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/div_result_display.sv
// Captures divider quotient/remainder, converts the quotient to BCD by serial double-dabble,
// and scans it plus the hex remainder onto a 4-digit display. Option: LEADING_ZERO_BLANK_EN.
module div_result_display
    import div_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] quotient,
    input  logic [3:0] remainder,
    input  logic       load,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int SR_W = BCD_WIDTH + 8;
    localparam int CW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    state_t          state;
    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_nxt;
    logic [2:0]      bit_cnt;
    logic [3:0]      rem_lat;
    logic [3:0]      dig_h, dig_t, dig_o, dig_r;
    logic            shown;
    logic [CW-1:0]   scan_cnt;
    logic [1:0]      idx;
    logic [3:0]      cur_dig;
    logic [3:0]      an_sel;
    logic            blank;
    logic [6:0]      dec_seg;

    // One double-dabble iteration: +3 on BCD nibbles >= 5, then shift left.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] r;
        r = v;
        for (int k = 0; k < BCD_WIDTH / 4; k++) begin
            if (r[8 + 4*k +: 4] >= 4'd5)
                r[8 + 4*k +: 4] = r[8 + 4*k +: 4] + 4'd3;
        end
        return {r[SR_W-2:0], 1'b0};
    endfunction

    assign sr_nxt = dabble_step(sr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            sr      <= '0;
            bit_cnt <= '0;
            rem_lat <= '0;
            dig_h   <= '0;
            dig_t   <= '0;
            dig_o   <= '0;
            dig_r   <= '0;
            shown   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_SHOW: begin
                    if (load) begin
                        state   <= S_CONV;
                        busy    <= 1'b1;
                        sr      <= {{BCD_WIDTH{1'b0}}, quotient};
                        bit_cnt <= '0;
                        rem_lat <= remainder;
                    end
                end
                S_CONV: begin
                    sr      <= sr_nxt;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        dig_h <= sr_nxt[19:16];
                        dig_t <= sr_nxt[15:12];
                        dig_o <= sr_nxt[11:8];
                        dig_r <= rem_lat;
                        shown <= 1'b1;
                        state <= S_SHOW;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Free-running digit scan, independent of the conversion FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        cur_dig = dig_h;
        an_sel  = 4'b0111;
        blank   = 1'b0;
        case (idx)
            2'd0: begin cur_dig = dig_h; an_sel = 4'b0111; end
            2'd1: begin cur_dig = dig_t; an_sel = 4'b1011; end
            2'd2: begin cur_dig = dig_o; an_sel = 4'b1101; end
            2'd3: begin cur_dig = dig_r; an_sel = 4'b1110; end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (state == S_SHOW) begin
            if (idx == 2'd0 && dig_h == 4'd0)
                blank = 1'b1;
            if (idx == 2'd1 && dig_h == 4'd0 && dig_t == 4'd0)
                blank = 1'b1;
        end
`endif
    end

    seg7_decode u_dec (
        .hex (cur_dig),
        .seg (dec_seg)
    );

    // Registered drive so anode and segments change together on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else if (!shown) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_sel;
            seg <= blank ? SEG_BLANK : dec_seg;
        end
    end

endmodule

// File: tb/tb_div_result_display.sv
// Scoreboard bench for div_result_display with SCAN_DIV=4; honours LEADING_ZERO_BLANK_EN.
module tb_div_result_display;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       load;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [10:0] exp_q[$];
    logic        mon_arm  = 1'b0;
    logic        mon_run  = 1'b0;
    logic        chk_hold = 1'b0;
    logic [3:0]  prev_an  = 4'hF;
    int          hold     = 0;

    div_result_display #(.SCAN_DIV(SD)) dut (
        .clk       (clk),
        .rst       (rst),
        .quotient  (quotient),
        .remainder (remainder),
        .load      (load),
        .busy      (busy),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] segof(input logic [3:0] d);
        logic [6:0] hi;
        case (d)
            4'h0: hi = 7'h3F; 4'h1: hi = 7'h06; 4'h2: hi = 7'h5B; 4'h3: hi = 7'h4F;
            4'h4: hi = 7'h66; 4'h5: hi = 7'h6D; 4'h6: hi = 7'h7D; 4'h7: hi = 7'h07;
            4'h8: hi = 7'h7F; 4'h9: hi = 7'h6F; 4'hA: hi = 7'h77; 4'hB: hi = 7'h7C;
            4'hC: hi = 7'h39; 4'hD: hi = 7'h5E; 4'hE: hi = 7'h79; default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    // Monitor: on each new anode, pop the expected {an,seg} and check the previous dwell.
    always @(negedge clk) begin
        logic [10:0] e;
        if (an !== prev_an) begin
            if (chk_hold) begin
                n_tests++;
                if (hold != SD) begin
                    n_fail++;
                    $display("FAIL hold_cycles an=%b got %0d expected %0d", prev_an, hold, SD);
                end
                chk_hold = 1'b0;
            end
            if (!mon_run && mon_arm && an == 4'b0111) begin
                mon_run = 1'b1;
                mon_arm = 1'b0;
            end
            if (mon_run) begin
                if (exp_q.size() == 0) begin
                    mon_run = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    n_tests++;
                    if ({an, seg} !== e) begin
                        n_fail++;
                        $display("FAIL digit got an=%b seg=%h expected an=%b seg=%h", an, seg, e[10:7], e[6:0]);
                    end
                    chk_hold = 1'b1;
                    if (exp_q.size() == 0) mon_run = 1'b0;
                end
            end
            hold = 1;
        end else begin
            hold++;
        end
        prev_an = an;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        exp_q.push_back({4'b0111, s0});
        exp_q.push_back({4'b1011, s1});
        exp_q.push_back({4'b1101, s2});
        exp_q.push_back({4'b1110, s3});
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        mon_arm = 1'b1;
        while ((exp_q.size() != 0 || mon_arm || mon_run) && n < 80) begin
            tick();
            n++;
        end
        if (n >= 80) begin
            n_tests++;
            n_fail++;
            $display("FAIL scan_timeout got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            mon_arm = 1'b0;
            mon_run = 1'b0;
        end
        repeat (6) tick();
    endtask

    // Load, then watch the 8 conversion cycles; optional extra load pulse or reset.
    task automatic run_conv(input logic [7:0] q, input logic [3:0] r,
                            input int pulse_at, input int rst_at, input logic from_idle);
        int hi;
        hi = 0;
        quotient  = q;
        remainder = r;
        load      = 1'b1;
        tick();
        load = 1'b0;
        if (from_idle) check("blank_in_conv", an, 4'hF);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_at) begin
                #1 rst = 1'b1;
                #1;
                check("async_rst_an", an, 4'hF);
                check("async_rst_seg", seg, 7'h7F);
                check("async_rst_busy", busy, 1'b0);
                return;
            end
            if (busy === 1'b1) hi++;
            load = (i == pulse_at);
            if (i == pulse_at) begin
                quotient  = 8'd9;
                remainder = 4'h5;
            end
            tick();
        end
        load = 1'b0;
        check("busy_len", hi, 8);
        check("busy_drop", busy, 1'b0);
    endtask

    initial begin
        int bad;
        rst = 1'b1; load = 1'b0; quotient = '0; remainder = '0;
        repeat (2) tick();
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_blank", an, 4'hF);

        // 0xFF / 3 from idle
        run_conv(8'hFF, 4'h3, -1, -1, 1'b1);
        check("blank_before_commit", an, 4'hF);
        push_frame(segof(4'd2), segof(4'd5), segof(4'd5), segof(4'h3));
        wait_drain();

        // reload from show, with an ignored load mid-conversion
        run_conv(8'd100, 4'hA, 3, -1, 1'b0);
        push_frame(segof(4'd1), segof(4'd0), segof(4'd0), segof(4'hA));
        wait_drain();

        // two full scan frames: wrap from index 3 back to 0
        push_frame(segof(4'd1), segof(4'd0), segof(4'd0), segof(4'hA));
        push_frame(segof(4'd1), segof(4'd0), segof(4'd0), segof(4'hA));
        wait_drain();

        // reset during conversion cycle 5
        run_conv(8'd55, 4'h1, -1, 4, 1'b0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (an !== 4'hF || seg !== 7'h7F || busy !== 1'b0) bad++;
        end
        check("no_commit_after_rst", bad, 0);

        // small quotient: leading zeros
        run_conv(8'd7, 4'h0, -1, -1, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
        push_frame(7'h7F, 7'h7F, segof(4'd7), segof(4'd0));
`else
        push_frame(segof(4'd0), segof(4'd0), segof(4'd7), segof(4'd0));
`endif
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
